// File: rtl/fft_pkg.sv
// Shared FFT definitions: complex sample layout and pair-buffer FSM states.
package fft_pkg;
  localparam int FLOAT_LEN = 32;
  localparam int CPLX_W    = 2 * FLOAT_LEN;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;
endpackage

// File: rtl/pair_buf_ram.sv
// Simple dual-port half-frame store with a 1-cycle registered read and no reset.
module pair_buf_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on a read, so it holds between pairs
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_pair_buffer.sv
// Buffers the first half of each frame and emits (x[k], x[k+N/2]) pairs as the
// second half streams in, one cycle after each accepted second-half sample.
module fft_pair_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W     = CPLX_W,
  parameter int HALF_DEPTH = 512,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              data_out_valid,
  output logic [ADDR_W-1:0] pair_idx,
  output logic              frame_last
);
  localparam int STAGES = 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(HALF_DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              accept, wr_en, rd_en;
  logic [STAGES:0]   vld_pipe;
  logic [DATA_W-1:0] x2_q, ram_q;
  logic              last_q, out_live;

  assign accept = data_in_valid & ~flush;
  assign wr_en  = accept & (state == FILL);
  assign rd_en  = accept & (state == PAIR);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = FILL;
      cnt_nxt   = '0;
    end else if (data_in_valid) begin
      cnt_nxt = cnt + ADDR_W'(1);
      if (cnt == LAST) state_nxt = (state == FILL) ? PAIR : FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign vld_pipe[0] = rd_en;

  // x2 and index are captured alongside the RAM read so they line up with x1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      x2_q     <= '0;
      pair_idx <= '0;
      last_q   <= 1'b0;
      out_live <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (rd_en) begin
        x2_q     <= data_in;
        pair_idx <= cnt;
        last_q   <= (cnt == LAST);
        out_live <= 1'b1;
      end
    end
  end

  pair_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (HALF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cnt),
    .wdata (data_in),
    .re    (rd_en),
    .raddr (cnt),
    .rdata (ram_q)
  );

  // RAM has no reset; mask its output until a pair has been read since reset
  assign data_out1      = out_live ? ram_q : '0;
  assign data_out2      = x2_q;
  assign data_out_valid = vld_pipe[STAGES];
  assign frame_last     = vld_pipe[STAGES] & last_q;
endmodule

// File: doc/fft_pair_buffer.md
FFT_PAIR_BUFFER -- requirements
Module: fft_pair_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 64; complex sample width (2 x 32-bit float, re high, im low).
REQ-002 SHALL have parameter HALF_DEPTH, default 512; samples per half-frame, power of two, 2..8192.
REQ-003 SHALL have parameter ADDR_W, default 9; equals log2(HALF_DEPTH).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous frame restart; the current partial frame is discarded.
REQ-007 SHALL have port data_in  input  DATA_W  input sample.
REQ-008 SHALL have port data_in_valid  input  1  data_in accepted this cycle.
REQ-009 SHALL have port data_out1  output  DATA_W  x1: the stored first-half sample.
REQ-010 SHALL have port data_out2  output  DATA_W  x2: the matching second-half sample.
REQ-011 SHALL have port data_out_valid  output  1  data_out1/data_out2 pair valid.
REQ-012 SHALL have port pair_idx  output  ADDR_W  index k of the pair (0..HALF_DEPTH-1), for twiddle addressing.
REQ-013 SHALL have port frame_last  output  1  high with the pair whose pair_idx = HALF_DEPTH-1.

Function
- REQ-014 SHALL hold a two-state FSM: FILL, PAIR. Reset state is FILL.
- REQ-015 SHALL hold an ADDR_W-bit sample counter cnt, which advances only on accepted samples (data_in_valid=1).
- REQ-016 In FILL, each accepted sample SHALL be written to RAM[cnt]. cnt wraps at HALF_DEPTH-1 and the FSM moves to PAIR.
- REQ-017 In PAIR, each accepted sample SHALL issue a RAM read of RAM[cnt] and register data_in as x2. cnt wraps at HALF_DEPTH-1 and the FSM moves back to FILL.
- REQ-018 Latency SHALL be exactly 1 cycle from the accepted PAIR sample to data_out_valid=1. data_out1=RAM[k], data_out2=that sample, pair_idx=k.
- REQ-019 data_out_valid SHALL be high only in the cycle after an accepted PAIR sample; gaps in data_in_valid produce matching gaps.
- REQ-020 Outputs SHALL hold their last values while data_out_valid=0.
- REQ-021 Back-to-back frames SHALL be supported with no dead cycle: the first FILL write of frame n+1 may occur in the cycle after the last PAIR read of frame n.
- REQ-022 A RAM address SHALL never be rewritten before its PAIR read for the same frame.
- REQ-023 On flush=1: cnt SHALL go to 0 and the FSM to FILL. A sample presented with flush is dropped. data_out_valid is 0 next cycle.
- REQ-024 flush SHALL take priority over data_in_valid.
- REQ-025 Control SHALL be fully synchronous counter-based; no logic clocked by status signals.
- REQ-026 There SHALL be no arithmetic on sample data; data passes bit-exact.

Reset
- REQ-027 On rst: FSM=FILL, cnt=0, data_out1=0, data_out2=0, data_out_valid=0, pair_idx=0, frame_last=0.
- REQ-028 RAM contents are not reset.
- REQ-029 Reset mid-frame SHALL discard the partial frame; the first sample accepted after deassertion is sample 0 of a new frame.

Structure
- REQ-030 Shared package fft_pkg SHALL hold FLOAT_LEN=32, CPLX_W=2*FLOAT_LEN, and FSM state encodings FILL/PAIR.
- REQ-031 There SHALL be one sub-module, pair_buf_ram: simple dual-port, HALF_DEPTH x DATA_W, 1-cycle synchronous read, BRAM-inferable, no reset.
- REQ-032 The RTL target is 120-400 lines including the RAM.

Verification (HALF_DEPTH=4, ADDR_W=2 unless noted)
- REQ-033 Continuous frame: inputs 1..8 with valid=1 -> pairs (1,5),(2,6),(3,7),(4,8) on 4 consecutive cycles; pair_idx 0..3; frame_last with (4,8); first pair one cycle after input 5.
- REQ-034 Gapped input: inputs 1..8 with valid toggling 1,0 -> same four pairs, each one cycle after its x2 input, valid gaps mirrored.
- REQ-035 Back-to-back frames: inputs 1..16 continuous -> pairs (1,5)..(4,8) then (9,13)..(12,16), with no missing pair.
- REQ-036 Flush: inputs 1..6, flush on the cycle after 6, then 11..18 -> only pairs (11,15)..(14,18) appear; no pair containing 1..6 after the flush.
- REQ-037 Async reset: rst asserted after input 6, mid-PAIR -> all outputs 0 immediately; after release, inputs 21..28 -> pairs (21,25)..(24,28).
- REQ-038 Default parameters: 1024 ramp samples 0..1023 -> pair k = (k, k+512) for k=0..511, with frame_last at k=511.
